// File: rtl/bcd_display_scanner_pkg.sv
// Shared constants for the BCD display scanner: digit count and the
// active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}.
package bcd_display_scanner_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NIBBLE_W   = 4;
    localparam int SEG_W      = 7;

    typedef logic [SEG_W-1:0] seg_t;

    localparam seg_t SEG_0    = 7'b1000000;
    localparam seg_t SEG_1    = 7'b1111001;
    localparam seg_t SEG_2    = 7'b0100100;
    localparam seg_t SEG_3    = 7'b0110000;
    localparam seg_t SEG_4    = 7'b0011001;
    localparam seg_t SEG_5    = 7'b0010010;
    localparam seg_t SEG_6    = 7'b0000010;
    localparam seg_t SEG_7    = 7'b1111000;
    localparam seg_t SEG_8    = 7'b0000000;
    localparam seg_t SEG_9    = 7'b0010000;
    localparam seg_t SEG_DASH = 7'b0111111;
    localparam seg_t SEG_OFF  = 7'b1111111;

endpackage

// File: rtl/bcd_display_scanner_bcd_to_7seg.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Non-decimal nibbles (10-15) render as a centre dash.
module bcd_to_7seg
    import bcd_display_scanner_pkg::*;
(
    input  logic [NIBBLE_W-1:0] bcd,
    output logic [SEG_W-1:0]    seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 4-digit seven-segment scanner with per-frame snapshot.
// Optional leading-zero suppression via LEADING_ZERO_BLANK_EN.
module bcd_display_scanner
    import bcd_display_scanner_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [NUM_DIGITS*NIBBLE_W-1:0] digits,
    input  logic                         blank,
    output logic [SEG_W-1:0]             seg,
    output logic [NUM_DIGITS-1:0]        an,
    output logic                         frame_done
);

    localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

    logic [PW-1:0]                  presc;
    logic [1:0]                     idx;
    logic [NUM_DIGITS*NIBBLE_W-1:0] snap;
    logic                           load_pending;
    logic                           tick;
    logic                           frame_end;
    logic [NIBBLE_W-1:0]            cur_nib;
    logic [SEG_W-1:0]               cur_seg;
    logic [NUM_DIGITS-1:0]          dark;
    logic [NUM_DIGITS-1:0]          an_next;

    assign tick      = (presc == PRESC_MAX);
    assign frame_end = tick && (idx == 2'd3);
    assign cur_nib   = snap[{idx, 2'b00} +: NIBBLE_W];

    bcd_to_7seg u_dec (
        .bcd (cur_nib),
        .seg (cur_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Digit i goes dark when it and every digit above it are zero.
    always_comb begin
        logic upper_zero;
        upper_zero = 1'b1;
        dark       = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (snap[i*NIBBLE_W +: NIBBLE_W] == '0);
            dark[i]    = upper_zero;
        end
    end
`else
    assign dark = '0;
`endif

    always_comb begin
        an_next = '1;
        if (!blank && !dark[idx])
            an_next[idx] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            presc        <= '0;
            idx          <= 2'd0;
            snap         <= '0;
            load_pending <= 1'b1;
            an           <= '1;
            seg          <= SEG_OFF;
            frame_done   <= 1'b0;
        end else begin
            presc        <= tick ? '0 : presc + 1'b1;
            if (tick)
                idx <= idx + 2'd1;
            // Snapshot only at frame boundaries so a frame never tears.
            if (load_pending || frame_end)
                snap <= digits;
            load_pending <= 1'b0;
            frame_done   <= frame_end;
            an           <= an_next;
            seg          <= cur_seg;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner with REFRESH_DIV = 4.
module tb_bcd_display_scanner;

    localparam int RD = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    // Per-slot anode patterns, listed {slot3, slot2, slot1, slot0}.
    localparam logic [15:0] AN_ALL = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [15:0] AN_LZ3 = {4'b1111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [15:0] AN_LZ2 = {4'b1111, 4'b1111, 4'b1101, 4'b1110};
    localparam logic [15:0] AN_LZ1 = {4'b1111, 4'b1111, 4'b1111, 4'b1110};
    localparam logic [15:0] AN_OFF = 16'hFFFF;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] digits = 16'h0;
    logic        blank = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    always #5 clk = ~clk;

    bcd_display_scanner #(.REFRESH_DIV(RD)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .digits     (digits),
        .blank      (blank),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [15:0]      digits;
        logic             blank;
        logic [3:0][3:0]  an;
        logic [3:0][6:0]  seg;
    } vec_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fd;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push_frame(input vec_t v);
        for (int s = 0; s < 4; s++)
            for (int c = 0; c < RD; c++)
                sb.push_back('{an: v.an[s], seg: v.seg[s], fd: (s == 3 && c == RD - 1)});
    endtask

    // Wait (bounded) for a frame_done pulse; returns sampled on that negedge.
    task automatic sync_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 64);
        if (!frame_done) begin
            total++;
            $display("FAIL frame_sync: no frame_done within 64 cycles");
        end
    endtask

    task automatic check_queue(input int ncyc, input int chg_at, input logic [15:0] chg_val);
        exp_t e;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                total++;
                $display("FAIL scoreboard: queue empty at cycle %0d", k);
            end else begin
                e = sb.pop_front();
                chk($sformatf("an[%0d]", k), 16'(an), 16'(e.an));
                if (e.an != 4'hF)
                    chk($sformatf("seg[%0d]", k), 16'(seg), 16'(e.seg));
                chk($sformatf("frame_done[%0d]", k), 16'(frame_done), 16'(e.fd));
            end
            if (k == chg_at) digits = chg_val;
        end
    endtask

    initial begin
        vecs[0] = '{digits: 16'h1234, blank: 1'b0, an: AN_ALL,
                    seg: {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        vecs[1] = '{digits: 16'h5678, blank: 1'b0, an: AN_ALL,
                    seg: {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}};
        vecs[2] = '{digits: 16'h00A5, blank: 1'b0, an: (LZB ? AN_LZ2 : AN_ALL),
                    seg: {7'b1000000, 7'b1000000, 7'b0111111, 7'b0010010}};
        vecs[3] = '{digits: 16'h0050, blank: 1'b0, an: (LZB ? AN_LZ2 : AN_ALL),
                    seg: {7'b1000000, 7'b1000000, 7'b0010010, 7'b1000000}};
        vecs[4] = '{digits: 16'h9087, blank: 1'b1, an: AN_OFF,
                    seg: {7'b0010000, 7'b1000000, 7'b0000000, 7'b1111000}};
        vecs[5] = '{digits: 16'h0000, blank: 1'b0, an: (LZB ? AN_LZ1 : AN_ALL),
                    seg: {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
        vecs[6] = '{digits: 16'h0F0B, blank: 1'b0, an: (LZB ? AN_LZ3 : AN_ALL),
                    seg: {7'b1000000, 7'b0111111, 7'b1000000, 7'b0111111}};
        vecs[7] = '{digits: 16'h9E09, blank: 1'b0, an: AN_ALL,
                    seg: {7'b0010000, 7'b0111111, 7'b1000000, 7'b0010000}};

        // Power-on reset held for two cycles.
        resetn = 1'b0;
        blank  = 1'b1;
        digits = 16'h1234;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_an", 16'(an), 16'h000F);
        chk("reset_seg", 16'(seg), 16'h007F);
        chk("reset_fd", 16'(frame_done), 16'h0000);
        blank  = 1'b0;
        resetn = 1'b1;

        // Table-driven frames: new digits take effect at the next boundary.
        foreach (vecs[i]) begin
            digits = vecs[i].digits;
            blank  = vecs[i].blank;
            sync_frame();
            push_frame(vecs[i]);
            check_queue(4 * RD, -1, 16'h0);
        end

        // Mid-frame change must not tear the current frame.
        blank  = 1'b0;
        digits = 16'h1234;
        sync_frame();
        push_frame(vecs[0]);
        push_frame(vecs[1]);
        check_queue(8 * RD, 5, 16'h5678);

        // Reset asserted during slot 2 (outputs already showing digit 2).
        digits = 16'h1234;
        sync_frame();
        repeat (2 * RD + 2) @(negedge clk);
        chk("slot2_an_before_reset", 16'(an), 16'h000B);
        resetn = 1'b0;
        blank  = 1'b1;
        @(negedge clk);
        chk("midreset_an", 16'(an), 16'h000F);
        chk("midreset_seg", 16'(seg), 16'h007F);
        chk("midreset_fd", 16'(frame_done), 16'h0000);
        resetn = 1'b1;
        blank  = 1'b0;
        digits = 16'h4321;
        for (int n = 1; n <= 4 * RD; n++) begin
            logic [15:0] exp_an;
            exp_an = AN_ALL;
            @(negedge clk);
            chk($sformatf("restart_an[%0d]", n), 16'(an), 16'(exp_an[((n - 1) / RD) * 4 +: 4]));
            if (n >= 2 && n <= RD)
                chk($sformatf("restart_seg[%0d]", n), 16'(seg), 16'(7'b1111001));
            chk($sformatf("restart_fd[%0d]", n), 16'(frame_done), 16'(n == 4 * RD));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
